// File: rtl/spi_cmd_scheduler_if.sv
// spi_cmd_scheduler_if: rx frame fields in (rx_*), motor command valid/ready out (cmd_*), status_etc and link_alive out
interface spi_cmd_scheduler_if;
  logic [7:0]  rx_xdata;
  logic [6:0]  rx_ydata;
  logic [16:0] rx_etc;
  logic        rx_valid;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic        cmd_mode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] status_etc;
  logic        link_alive;
  modport slave (
    input  rx_xdata, rx_ydata, rx_etc, rx_valid, cmd_ready,
    output cmd_x, cmd_y, cmd_mode, cmd_valid, status_etc, link_alive
  );
  modport master (
    output rx_xdata, rx_ydata, rx_etc, rx_valid, cmd_ready,
    input  cmd_x, cmd_y, cmd_mode, cmd_valid, status_etc, link_alive
  );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: validates SPI frames into a 2-entry command FIFO with link watchdog and fail-safe centring; ports clk, reset, bus (spi_cmd_scheduler_if.slave)
module spi_cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  X_CENTER       = 8'd128,
  parameter logic [6:0]  Y_CENTER       = 7'd64
) (
  input logic                clk,
  input logic                reset,
  spi_cmd_scheduler_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {LINK_DOWN, ACTIVE, FAILSAFE} state_t;
  state_t          state, state_nx;
  logic            s1_valid, s1_good, s1_mode;
  logic [7:0]      s1_x;
  logic [6:0]      s1_y;
  logic [4:0]      s1_seq;
  logic [4:0]      last_seq;
  logic            seen;
  logic [2:0]      crc_err;
  logic [1:0]      ovf;
  logic [WDW-1:0]  wd;
  logic [15:0]     mem [2];
  logic            rd;
  logic [1:0]      cnt;
  logic [7:0]      exp_sum;
  logic [15:0]     entry, head;
  logic            accept, timeout, fs, full, pop, flush;
  logic            unused_rsv;
  assign unused_rsv = ^bus.rx_etc[10:8];
  assign exp_sum = bus.rx_xdata + {1'b0, bus.rx_ydata} + {3'b0, bus.rx_etc[16:12]} + {7'b0, bus.rx_etc[11]};
  assign accept  = s1_valid && s1_good && !(seen && s1_seq == last_seq);
  assign timeout = wd == WDW'(TIMEOUT_CYCLES);
  assign fs      = state == FAILSAFE;
  assign full    = cnt == 2'd2;
  assign head    = mem[rd];
  assign entry   = {s1_x, s1_y, s1_mode};
  assign pop     = !fs && cnt != 2'd0 && bus.cmd_ready;
  assign flush   = state == ACTIVE && timeout && !accept;
  assign bus.cmd_valid  = fs || cnt != 2'd0;
  assign bus.cmd_x      = fs ? X_CENTER : head[15:8];
  assign bus.cmd_y      = fs ? Y_CENTER : head[7:1];
  assign bus.cmd_mode   = fs | head[0];
  assign bus.link_alive = state == ACTIVE;
  assign bus.status_etc = {state == ACTIVE, seen ? last_seq : 5'd0, crc_err, ovf, full, fs};
  always_comb begin
    state_nx = state;
    if (state == LINK_DOWN && accept) state_nx = ACTIVE;
    if (flush) state_nx = FAILSAFE;
    if (fs && bus.cmd_ready) state_nx = (cnt != 2'd0 || accept) ? ACTIVE : LINK_DOWN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LINK_DOWN;
      s1_valid <= 1'b0;
      s1_good  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_seq   <= '0;
      s1_mode  <= 1'b0;
      last_seq <= 5'h1F;
      seen     <= 1'b0;
      crc_err  <= '0;
      wd       <= '0;
    end else begin
      state    <= state_nx;
      s1_valid <= bus.rx_valid;
      s1_good  <= bus.rx_etc[7:0] == exp_sum;
      s1_x     <= bus.rx_xdata;
      s1_y     <= bus.rx_ydata;
      s1_seq   <= bus.rx_etc[16:12];
      s1_mode  <= bus.rx_etc[11];
      if (accept) begin
        last_seq <= s1_seq;
        seen     <= 1'b1;
      end
      if (s1_valid && !s1_good && crc_err != 3'd7) crc_err <= crc_err + 3'd1;
      wd <= accept ? '0 : timeout ? wd : wd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rd     <= 1'b0;
      ovf    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (accept && full && !pop) mem[~rd] <= entry;
      else if (accept && full) mem[rd] <= entry;
      else if (accept) mem[rd ^ cnt[0]] <= entry;
      if (accept && full && !pop && ovf != 2'd3) ovf <= ovf + 2'd1;
      if (pop) rd <= ~rd;
      cnt <= (accept && !pop && !full) ? cnt + 2'd1 : (pop && !accept) ? cnt - 2'd1 : cnt;
    end
  end
endmodule

// File: doc/spi_cmd_scheduler.md
Name: spi_cmd_scheduler

Overview:
- Sits between the SPI slave frame interface and the motor driver.
- Validates each received MOSI frame (checksum, sequence number) and buffers accepted commands in a 2-entry FIFO. Commands are issued to the motor driver over a valid/ready handshake.
- A link watchdog detects loss of the SPI master. On loss, the block issues one fail-safe centring command.
- Exports a 13-bit status word, which feeds the MISO etc field returned to the master.

Parameters:
TIMEOUT_CYCLES, 1000000, cycles without an accepted frame before the link is declared down
X_CENTER, 8'd128, fail-safe X command
Y_CENTER, 7'd64, fail-safe Y command

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_xdata  in  8  received motor X (MOSI frame [31:24])
rx_ydata  in  7  received motor Y (MOSI frame [23:17])
rx_etc  in  17  received etc field: [16:12] seq, [11] mode, [10:8] reserved, [7:0] checksum
rx_valid  in  1  one-cycle pulse: frame fields valid
cmd_x  out  8  command X to motor driver
cmd_y  out  7  command Y to motor driver
cmd_mode  out  1  command mode (1 = absolute move, 0 = hold)
cmd_valid  out  1  command available
cmd_ready  in  1  motor driver accepts command
status_etc  out  13  status word for the MISO etc field
link_alive  out  1  link up

Behaviour:
- Reset (synchronous):
  - All outputs go to 0, FIFO empty, counters 0, state LINK_DOWN.
  - last_seq = 5'h1F with a no-frame-yet flag set, so the first frame is never treated as a duplicate.
- Checksum:
  - exp = (rx_xdata + {1'b0,rx_ydata} + {3'b0,seq} + {7'b0,mode}) mod 256.
  - A frame is good when rx_etc[7:0] == exp. Reserved bits are ignored.
- Stage 1 (edge after rx_valid):
  - Frame and check results are registered.
  - Bad checksum: drop the frame; crc_err increments, saturating at 7.
  - Good checksum with seq == last_seq (after the first frame): drop as duplicate; no counter change, no watchdog kick.
  - Otherwise the frame is accepted: last_seq <= seq, watchdog counter cleared, FIFO written on that edge.
- Latency: rx_valid in cycle N gives cmd_valid high in cycle N+2 when the FIFO was empty.
- FIFO:
  - 2 entries of {x, y, mode}; cmd_* show the head entry.
  - Pop when cmd_valid && cmd_ready.
  - Push when full and no pop in the same cycle: the tail entry is overwritten (newest command wins) and ovf increments, saturating at 3.
  - Push and pop in the same cycle when full: pop then push, no overflow.
  - Push when empty with cmd_ready high: the entry still appears for at least one cycle (no bypass).
- Watchdog:
  - Counts up every cycle and is cleared on accept.
  - Saturates at TIMEOUT_CYCLES.
  - Timeout is counter == TIMEOUT_CYCLES.
- State machine:
  - LINK_DOWN: link_alive=0. An accepted frame moves to ACTIVE. No fail-safe is issued out of reset.
  - ACTIVE: link_alive=1. Timeout flushes the FIFO and moves to FAILSAFE.
  - FAILSAFE:
    - link_alive=0, cmd_valid=1, cmd = {X_CENTER, Y_CENTER, mode=1}, held stable until cmd_ready, then moves to LINK_DOWN.
    - Frames accepted during FAILSAFE are pushed to the FIFO and presented only after the fail-safe handshake. The FSM then goes to ACTIVE rather than LINK_DOWN.
    - A timeout coinciding with an accept: the accept wins, the counter clears, and there is no fail-safe.
- status_etc:
  - [12] link_alive
  - [11:7] last_seq
  - [6:4] crc_err
  - [3:2] ovf
  - [1] fifo_full
  - [0] failsafe (state == FAILSAFE)
  - All fields are registered.
  - Counters clear only on reset.
- Reset asserted mid-handshake: cmd_valid drops on the next edge, FIFO is emptied, no command is completed.

Test Plan:
- Good frame: x=8'h40, y=7'h20, seq=1, mode=1, checksum=8'h62 (cmd_ready=1) -> cmd_valid high at N+2 with cmd_x=40, cmd_y=20, cmd_mode=1; link_alive=1; status_etc[11:7]=1.
- Same frame with checksum=8'h63 -> nothing issued; status_etc[6:4]=1. Repeat 9 times -> field saturates at 7.
- Duplicate seq=1 resent, then seq=2 -> only the seq=2 command is issued; crc_err unchanged.
- cmd_ready=0, three good frames seq 3, 4, 5 -> FIFO holds seq 3 and seq 5 (seq 4 overwritten); ovf=1; fifo_full=1. Raise cmd_ready -> commands come out in order 3, 5.
- TIMEOUT_CYCLES=16, good frame then silence:
  - After 16 cycles: link_alive=0, status_etc[0]=1, cmd=(128,64,1) held while cmd_ready=0.
  - Then cmd_ready=1 -> one handshake, state LINK_DOWN, cmd_valid=0.
- Reset asserted during FAILSAFE with cmd_ready=0 -> next cycle cmd_valid=0, status_etc=0, link_alive=0.
